// File: rtl/cic_decim_param.sv
// ----------------------------------------------------------------------------
// cic_decim_param
//   CIC decimator for a 1-bit sigma-delta bitstream. Filter order, maximum
//   decimation and output width are fixed at elaboration; the decimation
//   ratio (D = 2^L) and the input coding (0/+1 or -1/+1) are chosen at run
//   time and take effect on frame boundaries. Combs are pipelined one stage
//   per cycle, the result is gain-normalised to OUT_W bits and presented
//   through a valid/ready register with a sticky overrun flag.
//
// Ports
//   clk, reset_n   modulator clock, asynchronous active-low reset
//   enable         1 = advance datapath, 0 = freeze (handshake keeps running)
//   in             modulator bit
//   bipolar        input coding: 0 -> {0,+1}, 1 -> {-1,+1}
//   dec_sel        requested log2 decimation, clamped to 1..MAX_LOG2_DEC
//   out_full       full-precision signed result
//   out_norm       normalised result (unsigned unipolar, signed bipolar)
//   out_valid      result available
//   out_ready      consumer accepts the result
//   overrun        sticky: an unread result was overwritten
//   clear_overrun  clears overrun (a simultaneous overwrite wins)
// ----------------------------------------------------------------------------
module cic_decim_param #(
  parameter int unsigned ORDER        = 3,
  parameter int unsigned MAX_LOG2_DEC = 8,
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned DATA_W       = ORDER * MAX_LOG2_DEC + 2,
  parameter int unsigned SEL_W        = $clog2(MAX_LOG2_DEC + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     in,
  input  logic                     bipolar,
  input  logic [SEL_W-1:0]         dec_sel,
  output logic signed [DATA_W-1:0] out_full,
  output logic [OUT_W-1:0]         out_norm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  input  logic                     clear_overrun
);

  localparam int unsigned CNT_W  = MAX_LOG2_DEC;
  localparam int unsigned DISC_W = $clog2(ORDER + 1);
  localparam int unsigned WIDE_W = DATA_W + OUT_W;

  localparam logic signed [WIDE_W-1:0] SAT_HI =
    {{(WIDE_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_LO =
    {{(WIDE_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Frame control state
  logic               lat_done;
  logic [SEL_W-1:0]   l_act;
  logic               bip_act;
  logic [CNT_W-1:0]   cnt;
  logic [DISC_W-1:0]  discard;

  // Integrator chain
  logic signed [DATA_W-1:0] integ [ORDER];

  // Comb pipeline: stage 0 holds the decimated sample, stage k is comb k
  logic signed [DATA_W-1:0] stg      [ORDER+1];
  logic signed [DATA_W-1:0] dly      [ORDER];
  logic                     stg_vld  [ORDER+1];
  logic                     stg_keep [ORDER+1];
  logic [SEL_W-1:0]         stg_l    [ORDER+1];
  logic                     stg_bip  [ORDER+1];

  // Combinational helpers
  logic [SEL_W-1:0]         l_in_c;
  logic [SEL_W-1:0]         l_eff_c;
  logic                     bip_eff_c;
  logic [CNT_W-1:0]         cnt_last_c;
  logic                     tc_c;
  logic                     chg_c;
  logic signed [DATA_W-1:0] x_c;
  logic                     load_c;
  int                       norm_s;
  logic signed [WIDE_W-1:0] norm_wide;
  logic signed [WIDE_W-1:0] norm_shf;
  logic [OUT_W-1:0]         norm_c;

  // Ratio clamp, active frame settings, terminal count and input coding.
  // Before the first enabled cycle the live inputs stand in for the latches.
  always_comb begin
    l_in_c = dec_sel;
    if (dec_sel == '0) begin
      l_in_c = SEL_W'(1);
    end else if (dec_sel > SEL_W'(MAX_LOG2_DEC)) begin
      l_in_c = SEL_W'(MAX_LOG2_DEC);
    end
    l_eff_c    = lat_done ? l_act : l_in_c;
    bip_eff_c  = lat_done ? bip_act : bipolar;
    cnt_last_c = ~({CNT_W{1'b1}} << l_eff_c);
    tc_c       = enable && (cnt == cnt_last_c);
    chg_c      = (l_in_c != l_eff_c) || (bipolar != bip_eff_c);
    if (in) begin
      x_c = DATA_W'(1);
    end else if (bip_eff_c) begin
      x_c = '1;
    end else begin
      x_c = '0;
    end
  end

  // Frame counter, setting latches and warm-up discard counter.
  // A frame closing at TC is judged by the discard count it started with;
  // a settings change only affects the frames that follow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_done <= 1'b0;
      l_act    <= '0;
      bip_act  <= 1'b0;
      cnt      <= '0;
      discard  <= DISC_W'(ORDER);
    end else if (enable) begin
      if (!lat_done) begin
        lat_done <= 1'b1;
        l_act    <= l_in_c;
        bip_act  <= bipolar;
      end
      if (tc_c) begin
        cnt     <= '0;
        l_act   <= l_in_c;
        bip_act <= bipolar;
        if (chg_c) begin
          discard <= DISC_W'(ORDER);
        end else if (discard != '0) begin
          discard <= discard - DISC_W'(1);
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Integrators wrap modulo 2^DATA_W; the comb differences undo the wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(ORDER); k++) begin
        integ[k] <= '0;
      end
    end else if (enable) begin
      integ[0] <= integ[0] + x_c;
      for (int k = 1; k < int'(ORDER); k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  // Decimation sample and comb pipeline; tags travel with each sample so the
  // result is normalised with the settings of the frame that produced it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= int'(ORDER); k++) begin
        stg[k]      <= '0;
        stg_vld[k]  <= 1'b0;
        stg_keep[k] <= 1'b0;
        stg_l[k]    <= '0;
        stg_bip[k]  <= 1'b0;
      end
      for (int k = 0; k < int'(ORDER); k++) begin
        dly[k] <= '0;
      end
    end else if (enable) begin
      stg_vld[0] <= tc_c;
      if (tc_c) begin
        stg[0]      <= integ[ORDER-1];
        stg_keep[0] <= (discard == '0);
        stg_l[0]    <= l_eff_c;
        stg_bip[0]  <= bip_eff_c;
      end
      for (int k = 1; k <= int'(ORDER); k++) begin
        stg_vld[k] <= stg_vld[k-1];
        if (stg_vld[k-1]) begin
          stg[k]      <= stg[k-1] - dly[k-1];
          dly[k-1]    <= stg[k-1];
          stg_keep[k] <= stg_keep[k-1];
          stg_l[k]    <= stg_l[k-1];
          stg_bip[k]  <= stg_bip[k-1];
        end
      end
    end
  end

  // Gain normalisation: shift by ORDER*L+1-OUT_W, saturate only when bipolar.
  always_comb begin
    norm_s    = int'(ORDER) * int'(stg_l[ORDER]) + 1 - int'(OUT_W);
    norm_wide = WIDE_W'(stg[ORDER]);
    if (norm_s >= 0) begin
      norm_shf = norm_wide >>> norm_s;
    end else begin
      norm_shf = norm_wide <<< (-norm_s);
    end
    norm_c = norm_shf[OUT_W-1:0];
    if (stg_bip[ORDER]) begin
      if (norm_shf > SAT_HI) begin
        norm_c = SAT_HI[OUT_W-1:0];
      end else if (norm_shf < SAT_LO) begin
        norm_c = SAT_LO[OUT_W-1:0];
      end
    end
  end

  assign load_c = enable && stg_vld[ORDER] && stg_keep[ORDER];

  // Output register and handshake; runs regardless of enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_full  <= '0;
      out_norm  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load_c) begin
        out_full  <= stg[ORDER];
        out_norm  <= norm_c;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (load_c && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_param.sv
// ----------------------------------------------------------------------------
// tb_cic_decim_param
//   Directed bench for cic_decim_param with default parameters
//   (ORDER=3, MAX_LOG2_DEC=8, OUT_W=16, DATA_W=26, SEL_W=4).
//   Stimulus changes and output sampling happen on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_cic_decim_param;

  localparam int DATA_W = 26;
  localparam int OUT_W  = 16;
  localparam int SEL_W  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              in_bit = 1'b0;
  logic              bipolar = 1'b0;
  logic [SEL_W-1:0]  dec_sel = '0;
  logic [DATA_W-1:0] out_full;
  logic [OUT_W-1:0]  out_norm;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              overrun;
  logic              clear_overrun = 1'b0;

  bit alt = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  cic_decim_param dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .in            (in_bit),
    .bipolar       (bipolar),
    .dec_sel       (dec_sel),
    .out_full      (out_full),
    .out_norm      (out_norm),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n falling edges; in alternating mode the bit toggles per enabled cycle.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (alt && enable) in_bit = ~in_bit;
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max_cyc) begin
      step(1);
      cyc++;
      if (out_valid) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    enable = 1'b0;
    alt = 1'b0;
    in_bit = 1'b0;
    bipolar = 1'b0;
    out_ready = 1'b1;
    clear_overrun = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_full !== '0) begin n_fail++; $display("FAIL reset_full: got %0d want 0", out_full); end
    n_checks++;
    if (out_norm !== '0) begin n_fail++; $display("FAIL reset_norm: got %h want 0", out_norm); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_unipolar_const();
    int cyc; bit seen;
    do_reset();
    dec_sel = 4'd8; in_bit = 1'b1; enable = 1'b1;
    wait_valid(1100, cyc, seen);
    n_checks++;
    if (!seen || cyc != 1028) begin n_fail++; $display("FAIL uni_latency: got %0d want 1028", cyc); end
    n_checks++;
    if (out_full !== 26'd16777216) begin n_fail++; $display("FAIL uni_full: got %0d want 16777216", out_full); end
    n_checks++;
    if (out_norm !== 16'h8000) begin n_fail++; $display("FAIL uni_norm: got %h want 8000", out_norm); end
  endtask

  task automatic test_bipolar();
    int cyc; bit seen;
    do_reset();
    dec_sel = 4'd8; bipolar = 1'b1; in_bit = 1'b0; enable = 1'b1;
    wait_valid(1100, cyc, seen);
    n_checks++;
    if (!seen || cyc != 1028) begin n_fail++; $display("FAIL bip_latency: got %0d want 1028", cyc); end
    n_checks++;
    if (out_full !== 26'h3000000) begin n_fail++; $display("FAIL bip_neg_full: got %h want 3000000", out_full); end
    n_checks++;
    if (out_norm !== 16'h8000) begin n_fail++; $display("FAIL bip_neg_norm: got %h want 8000", out_norm); end
    in_bit = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid(300, cyc, seen);
      n_checks++;
      if (!seen || cyc != 256) begin n_fail++; $display("FAIL bip_period%0d: got %0d want 256", k, cyc); end
    end
    n_checks++;
    if (out_full !== 26'd16777216) begin n_fail++; $display("FAIL bip_pos_full: got %0d want 16777216", out_full); end
    n_checks++;
    if (out_norm !== 16'h7FFF) begin n_fail++; $display("FAIL bip_pos_norm: got %h want 7fff", out_norm); end
  endtask

  task automatic test_alternating_freeze();
    int cyc; bit seen;
    do_reset();
    dec_sel = 4'd4; in_bit = 1'b1; alt = 1'b1; enable = 1'b1;
    wait_valid(100, cyc, seen);
    n_checks++;
    if (!seen || cyc != 68) begin n_fail++; $display("FAIL alt_latency: got %0d want 68", cyc); end
    n_checks++;
    if (out_full !== 26'd2048) begin n_fail++; $display("FAIL alt_full: got %0d want 2048", out_full); end
    n_checks++;
    if (out_norm !== 16'h4000) begin n_fail++; $display("FAIL alt_norm: got %h want 4000", out_norm); end
    wait_valid(30, cyc, seen);
    n_checks++;
    if (!seen || cyc != 16) begin n_fail++; $display("FAIL alt_period: got %0d want 16", cyc); end
    n_checks++;
    if (out_full !== 26'd2048) begin n_fail++; $display("FAIL alt_full2: got %0d want 2048", out_full); end
    step(5);
    enable = 1'b0;
    step(20);
    enable = 1'b1;
    wait_valid(60, cyc, seen);
    n_checks++;
    if (!seen || cyc + 25 != 36) begin n_fail++; $display("FAIL freeze_period: got %0d want 36", cyc + 25); end
    n_checks++;
    if (out_full !== 26'd2048) begin n_fail++; $display("FAIL freeze_full: got %0d want 2048", out_full); end
  endtask

  task automatic test_overrun();
    int cyc; bit seen;
    do_reset();
    dec_sel = 4'd4; in_bit = 1'b1; alt = 1'b1; enable = 1'b1;
    wait_valid(100, cyc, seen);
    n_checks++;
    if (!seen || cyc != 68) begin n_fail++; $display("FAIL ovr_latency: got %0d want 68", cyc); end
    out_ready = 1'b0; alt = 1'b0; in_bit = 1'b1;
    step(64);
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", out_valid); end
    n_checks++;
    if (out_full !== 26'd4096) begin n_fail++; $display("FAIL ovr_latest_full: got %0d want 4096", out_full); end
    n_checks++;
    if (out_norm !== 16'h8000) begin n_fail++; $display("FAIL ovr_latest_norm: got %h want 8000", out_norm); end
    step(15);
    clear_overrun = 1'b1;
    step(1);
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_beats_clear: got %b want 1", overrun); end
    step(1);
    clear_overrun = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    n_checks++;
    if (out_full !== 26'd4096) begin n_fail++; $display("FAIL ovr_hold_full: got %0d want 4096", out_full); end
    out_ready = 1'b1;
    step(1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got %b want 0", out_valid); end
  endtask

  task automatic test_ratio_change();
    int cyc; bit seen;
    do_reset();
    dec_sel = 4'd8; in_bit = 1'b1; alt = 1'b1; enable = 1'b1;
    wait_valid(1100, cyc, seen);
    n_checks++;
    if (!seen || cyc != 1028) begin n_fail++; $display("FAIL chg_latency: got %0d want 1028", cyc); end
    n_checks++;
    if (out_full !== 26'd8388608) begin n_fail++; $display("FAIL chg_l8_full: got %0d want 8388608", out_full); end
    step(10);
    dec_sel = 4'd4;
    wait_valid(300, cyc, seen);
    n_checks++;
    if (!seen || cyc != 246) begin n_fail++; $display("FAIL chg_last_old: got %0d want 246", cyc); end
    n_checks++;
    if (out_full !== 26'd8388608) begin n_fail++; $display("FAIL chg_old_full: got %0d want 8388608", out_full); end
    n_checks++;
    if (out_norm !== 16'h4000) begin n_fail++; $display("FAIL chg_old_norm: got %h want 4000", out_norm); end
    wait_valid(100, cyc, seen);
    n_checks++;
    if (!seen || cyc != 64) begin n_fail++; $display("FAIL chg_drop3: got %0d want 64", cyc); end
    n_checks++;
    if (out_full !== 26'd2048) begin n_fail++; $display("FAIL chg_new_full: got %0d want 2048", out_full); end
    n_checks++;
    if (out_norm !== 16'h4000) begin n_fail++; $display("FAIL chg_new_norm: got %h want 4000", out_norm); end
    wait_valid(30, cyc, seen);
    n_checks++;
    if (!seen || cyc != 16) begin n_fail++; $display("FAIL chg_new_period: got %0d want 16", cyc); end
  endtask

  task automatic test_dec_sel_clamp();
    int cyc; bit seen;
    do_reset();
    dec_sel = 4'd0; in_bit = 1'b1; enable = 1'b1;
    wait_valid(40, cyc, seen);
    n_checks++;
    if (!seen || cyc != 12) begin n_fail++; $display("FAIL clamp0_latency: got %0d want 12", cyc); end
    n_checks++;
    if (out_full !== 26'd8) begin n_fail++; $display("FAIL clamp0_full: got %0d want 8", out_full); end
    n_checks++;
    if (out_norm !== 16'h8000) begin n_fail++; $display("FAIL clamp0_norm: got %h want 8000", out_norm); end
    do_reset();
    dec_sel = 4'd15; in_bit = 1'b1; enable = 1'b1;
    wait_valid(1100, cyc, seen);
    n_checks++;
    if (!seen || cyc != 1028) begin n_fail++; $display("FAIL clamp15_latency: got %0d want 1028", cyc); end
    n_checks++;
    if (out_full !== 26'd16777216) begin n_fail++; $display("FAIL clamp15_full: got %0d want 16777216", out_full); end
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit seen;
    do_reset();
    dec_sel = 4'd1; in_bit = 1'b1; enable = 1'b1; out_ready = 1'b0;
    wait_valid(40, cyc, seen);
    step(5);
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL mid_pre_overrun: got %b want 1", overrun); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_full !== '0) begin n_fail++; $display("FAIL mid_full: got %0d want 0", out_full); end
    n_checks++;
    if (out_norm !== '0) begin n_fail++; $display("FAIL mid_norm: got %h want 0", out_norm); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_overrun: got %b want 0", overrun); end
    step(1);
    reset_n = 1'b1;
    out_ready = 1'b1;
    wait_valid(40, cyc, seen);
    n_checks++;
    if (!seen || cyc != 12) begin n_fail++; $display("FAIL mid_warmup: got %0d want 12", cyc); end
    n_checks++;
    if (out_full !== 26'd8) begin n_fail++; $display("FAIL mid_full_after: got %0d want 8", out_full); end
  endtask

  initial begin
    test_reset();
    test_unipolar_const();
    test_bipolar();
    test_alternating_freeze();
    test_overrun();
    test_ratio_change();
    test_dec_sel_clamp();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
